// File: rtl/alu_pkg.sv
// Shared definitions for the ALU adder path: widths, response-buffer states
// and the round-robin pick helper used by the arbiter.
package alu_pkg;

    localparam int ADD_WIDTH = 32;
    localparam int MAX_REQ   = 8;
    localparam int REQ_ID_W  = 2;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // First valid index scanning ptr, ptr+1, ... mod n. Falls back to ptr when
    // nothing is valid; callers qualify the result with any-valid.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [2:0] pick;
        int         idx;
        pick = ptr;
        // Walk offsets from the far end so the closest valid offset wins last.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx]) begin
                    pick = 3'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder_core.sv
// Combinational adder built from 4-bit carry-lookahead groups with the group
// carries chained between groups; carry-in is fixed at zero.
module adder_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW:0]   c;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;

    assign a_ext = PW'(a);
    assign b_ext = PW'(b);
    assign g     = a_ext & b_ext;
    assign p     = a_ext ^ b_ext;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_group
            localparam int B = gi * 4;
            assign c[B]   = grp_c[gi];
            assign c[B+1] = g[B] | (p[B] & grp_c[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
            assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign grp_p[gi] = &p[B+3:B];
        end
    endgenerate

    always_comb begin
        grp_c[0] = 1'b0;
        for (int i = 0; i < NG; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
    end

    assign c[PW] = grp_c[NG];
    // Padding bits are zero, so the carry into bit WIDTH is the true carry-out.
    assign sum   = p[WIDTH-1:0] ^ c[WIDTH-1:0];
    assign cout  = c[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared adder, with a single-entry response
// buffer (EMPTY/FULL) and a wrapping accepted-operation counter.
module adder_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = ADD_WIDTH,
    parameter int IDW     = REQ_ID_W,
    parameter int CNTW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_sum,
    output logic                     resp_carry,
    output logic [IDW-1:0]           resp_id,
    output logic [CNTW-1:0]          op_count
);

    buf_state_t      state_reg, state_next;
    logic [WIDTH-1:0] resp_sum_reg, resp_sum_next;
    logic             resp_carry_reg, resp_carry_next;
    logic [IDW-1:0]   resp_id_reg, resp_id_next;
    logic [CNTW-1:0]  op_count_reg, op_count_next;
    logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] core_sum;
    logic             core_cout;
    logic [IDW-1:0]   grant;
    logic             any_valid;
    logic             can_accept;
    logic             accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
            assign req_ready[gi] = accept & (grant == IDW'(gi));
        end
    endgenerate

    // Grant is a function of req_valid and the pointer only; backpressure
    // gates req_ready but never changes who is selected.
    assign grant      = IDW'(rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr_reg), NUM_REQ));
    assign any_valid  = |req_valid;
    assign resp_valid = (state_reg == BUF_FULL);
    assign can_accept = ~resp_valid | resp_ready;
    assign accept     = any_valid & can_accept;

    assign a_sel = a_arr[grant];
    assign b_sel = b_arr[grant];

    adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (a_sel),
        .b    (b_sel),
        .sum  (core_sum),
        .cout (core_cout)
    );

    always_comb begin
        state_next      = state_reg;
        resp_sum_next   = resp_sum_reg;
        resp_carry_next = resp_carry_reg;
        resp_id_next    = resp_id_reg;
        op_count_next   = op_count_reg;
        rr_ptr_next     = rr_ptr_reg;

        case (state_reg)
            BUF_EMPTY: if (accept) state_next = BUF_FULL;
            BUF_FULL:  if (!accept && resp_ready) state_next = BUF_EMPTY;
            default:   state_next = BUF_EMPTY;
        endcase

        // A drain and an accept in the same cycle simply overwrite the entry.
        if (accept) begin
            resp_sum_next   = core_sum;
            resp_carry_next = core_cout;
            resp_id_next    = grant;
            op_count_next   = op_count_reg + 1'b1;
            rr_ptr_next     = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= BUF_EMPTY;
            resp_sum_reg   <= '0;
            resp_carry_reg <= 1'b0;
            resp_id_reg    <= '0;
            op_count_reg   <= '0;
            rr_ptr_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            resp_sum_reg   <= resp_sum_next;
            resp_carry_reg <= resp_carry_next;
            resp_id_reg    <= resp_id_next;
            op_count_reg   <= op_count_next;
            rr_ptr_reg     <= rr_ptr_next;
        end
    end

    assign resp_sum   = resp_sum_reg;
    assign resp_carry = resp_carry_reg;
    assign resp_id    = resp_id_reg;
    assign op_count   = op_count_reg;

endmodule
